// File: rtl/taiga_fifo_ext.sv
// taiga_fifo_ext: first-word-fall-through FIFO of arbitrary depth with occupancy,
// almost-full, flush and sticky error flags. Optional peak tracking: TAIGA_FIFO_PEAK_EN.
module taiga_fifo_ext #(
    parameter int DATA_WIDTH         = 70,
    parameter int FIFO_DEPTH         = 6,
    parameter int ALMOST_FULL_THRESH = FIFO_DEPTH - 1,
    localparam int PTR_W             = $clog2(FIFO_DEPTH),
    localparam int CNT_W             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic [CNT_W-1:0]      peak_count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_acc;
    logic             pop_acc;

    // Depth need not be a power of two, so wrap explicitly at the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid       = (count_q != '0);
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign almost_full = (count_q >= CNT_W'(ALMOST_FULL_THRESH));
    assign count       = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign data_out    = mem[rptr_q];

    assign pop_acc  = pop & valid;
    assign push_acc = push & (~full | pop_acc);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_acc) wptr_d = ptr_inc(wptr_q);
            if (pop_acc)  rptr_d = ptr_inc(rptr_q);
            unique case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push & ~push_acc) ovf_d = 1'b1;
            if (pop & ~pop_acc)   unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset; valid gates its contents.
    always_ff @(posedge clk) begin
        if (push_acc & ~flush) mem[wptr_q] <= data_in;
    end

`ifdef TAIGA_FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush)                peak_d = '0;
        else if (count_d > peak_q) peak_d = count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_taiga_fifo_ext.sv
// Self-checking bench for taiga_fifo_ext (depth 6, almost-full threshold 4)
// against a queue-based reference model.
module tb_taiga_fifo_ext;

    localparam int DW  = 70;
    localparam int DEP = 6;
    localparam int AFT = 4;
    localparam int CW  = $clog2(DEP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow_err;
    logic          underflow_err;
    logic [CW-1:0] peak_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    int            m_peak;

    taiga_fifo_ext #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEP),
        .ALMOST_FULL_THRESH(AFT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .data_in(data_in),
        .pop(pop),
        .flush(flush),
        .data_out(data_out),
        .valid(valid),
        .full(full),
        .almost_full(almost_full),
        .count(count),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err),
        .peak_count(peak_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_peak();
`ifdef TAIGA_FIFO_PEAK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_peak = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; the model applies the accept rules to pre-edge state.
    task automatic drive(input bit p, input logic [DW-1:0] d,
                         input bit po, input bit fl);
        bit pa, pu;
        push = p; data_in = d; pop = po; flush = fl;
        pa = po && (q.size() != 0);
        pu = p && ((q.size() != DEP) || pa);
        if (fl) begin
            q.delete();
            m_peak = 0;
        end else begin
            if (p && !pu) m_ovf = 1;
            if (po && !pa) m_unf = 1;
            if (pa) void'(q.pop_front());
            if (pu) q.push_back(d);
            if (q.size() > m_peak) m_peak = q.size();
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid, full, almost_full, overflow_err, underflow_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000",
                     {valid, full, almost_full, overflow_err, underflow_err});
        end
        checks++;
        if (count !== 0 || peak_count !== 0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%0d want=0/0", count, peak_count);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= DEP; i++) begin
            drive(1, DW'(i), 0, 0);
            checks++;
            if (int'(count) !== i) begin
                errors++;
                $display("FAIL fill_count got=%0d want=%0d", count, i);
            end
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got=%b want=1", full);
        end
        for (int i = 1; i <= DEP; i++) begin
            checks++;
            if (data_out !== DW'(i) || valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_data got=%0h/%b want=%0h/1", data_out, valid, i);
            end
            drive(0, '0, 1, 0);
        end
        checks++;
        if (valid !== 1'b0 || count !== 0) begin
            errors++;
            $display("FAIL drain_empty got=%b/%0d want=0/0", valid, count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < DEP; i++) drive(1, DW'(8'h10 + i), 0, 0);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'(8'h20 + i), 0, 0);
            checks++;
            if (int'(count) > DEP || int'(count) !== q.size()) begin
                errors++;
                $display("FAIL wrap_count got=%0d want=%0d", count, q.size());
            end
        end
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf got=%b want=1", overflow_err);
        end
        while (q.size() != 0) begin
            checks++;
            if (data_out !== q[0]) begin
                errors++;
                $display("FAIL wrap_order got=%0h want=%0h", data_out, q[0]);
            end
            drive(0, '0, 1, 0);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= DEP; i++) drive(1, DW'(i), 0, 0);
        drive(1, DW'(8'hAA), 1, 0);
        checks++;
        if (count !== CW'(DEP) || data_out !== DW'(2) || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL fullpp got=%0d/%0h/%b want=6/2/0", count, data_out, overflow_err);
        end
        drive(1, DW'(8'hBB), 0, 0);
        checks++;
        if (count !== CW'(DEP) || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL full_drop got=%0d/%b want=6/1", count, overflow_err);
        end
        for (int i = 0; i < DEP - 1; i++) drive(0, '0, 1, 0);
        checks++;
        if (data_out !== DW'(8'hAA) || count !== 1) begin
            errors++;
            $display("FAIL full_last got=%0h/%0d want=aa/1", data_out, count);
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        drive(1, DW'(5), 1, 0);
        checks++;
        if (count !== 1 || data_out !== DW'(5) || underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL emptypp got=%0d/%0h/%b want=1/5/1", count, data_out, underflow_err);
        end
        do_reset();
        drive(0, '0, 1, 0);
        checks++;
        if (underflow_err !== 1'b1 || count !== 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL lone_pop got=%b/%0d/%b want=1/0/0", underflow_err, count, valid);
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 1; i <= AFT; i++) begin
            drive(1, DW'(i), 0, 0);
            checks++;
            if (almost_full !== (i >= AFT)) begin
                errors++;
                $display("FAIL af_rise cnt=%0d got=%b want=%b", i, almost_full, i >= AFT);
            end
        end
        drive(0, '0, 1, 0);
        checks++;
        if (almost_full !== 1'b0 || count !== 3) begin
            errors++;
            $display("FAIL af_fall got=%b/%0d want=0/3", almost_full, count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, '0, 1, 0);
        for (int i = 1; i <= 5; i++) drive(1, DW'(i), 0, 0);
        checks++;
        if (int'(peak_count) !== exp_peak()) begin
            errors++;
            $display("FAIL peak_pre got=%0d want=%0d", peak_count, exp_peak());
        end
        drive(1, DW'(8'h77), 0, 1);
        checks++;
        if (count !== 0 || valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL flush got=%0d/%b/%b/%b want=0/0/0/1",
                     count, valid, overflow_err, underflow_err);
        end
        checks++;
        if (peak_count !== 0) begin
            errors++;
            $display("FAIL peak_post got=%0d want=0", peak_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) drive(1, DW'(i), 0, 0);
        drive(0, '0, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 0 || valid !== 1'b0 || underflow_err !== 1'b0 || peak_count !== 0) begin
            errors++;
            $display("FAIL async_rst got=%0d/%b/%b/%0d want=0/0/0/0",
                     count, valid, underflow_err, peak_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_valid got=%b want=0", valid);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        bit p, po, fl;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            d  = {6'($urandom()), $urandom(), $urandom()};
            p  = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            drive(p, d, po, fl);
            checks++;
            if (int'(count) !== q.size() || valid !== (q.size() != 0) ||
                full !== (q.size() == DEP) || almost_full !== (q.size() >= AFT)) begin
                errors++;
                $display("FAIL rnd_state n=%0d got=%0d/%b/%b/%b want=%0d", n,
                         count, valid, full, almost_full, q.size());
            end
            checks++;
            if (overflow_err !== m_ovf || underflow_err !== m_unf ||
                int'(peak_count) !== exp_peak()) begin
                errors++;
                $display("FAIL rnd_flags n=%0d got=%b/%b/%0d want=%b/%b/%0d", n,
                         overflow_err, underflow_err, peak_count, m_ovf, m_unf, exp_peak());
            end
            if (q.size() != 0) begin
                checks++;
                if (data_out !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_data n=%0d got=%0h want=%0h", n, data_out, q[0]);
                end
            end
            if (n == 1500) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_push_pop();
        test_empty_push_pop();
        test_almost_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
